// File: rtl/mem_op_pkg.sv
// mem_op_pkg: memory operation encoding shared by decode, execute and the
// load/store stage, plus helpers that classify an operation.
//   mem_op_t - 4-bit operation code (MEM_NONE, loads, stores)
//   is_load  - 1 for LB/LH/LW/LBU/LHU
//   is_store - 1 for SB/SH/SW
package mem_op_pkg;
  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    LB       = 4'd1,
    LH       = 4'd2,
    LW       = 4'd3,
    LBU      = 4'd4,
    LHU      = 4'd5,
    SB       = 4'd6,
    SH       = 4'd7,
    SW       = 4'd8
  } mem_op_t;

  function automatic logic is_load(input mem_op_t op);
    return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction
endpackage

// File: rtl/type_pkg.sv
// type_pkg: shared scalar widths for the core datapath.
//   addr_t - 32-bit byte address
//   data_t - 32-bit data word
package type_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
endpackage

// File: rtl/load_extend.sv
// load_extend: combinational load-data extraction. Shifts the raw memory word
// so the addressed byte/halfword sits at bit 0, then sign- or zero-extends it.
//   op      in  mem_op_t  load operation (non-loads give 0)
//   addr_lo in  2         byte offset, already aligned for the access size
//   raw     in  data_t    raw word returned by data memory
//   ext     out data_t    extended load result
module load_extend
  import type_pkg::*;
  import mem_op_pkg::*;
(
  input  mem_op_t    op,
  input  logic [1:0] addr_lo,
  input  data_t      raw,
  output data_t      ext
);

  data_t sh;

  always_comb begin
    sh  = raw >> {addr_lo, 3'b000};
    ext = '0;
    case (op)
      LB:      ext = {{24{sh[7]}}, sh[7:0]};
      LBU:     ext = {24'h000000, sh[7:0]};
      LH:      ext = {{16{sh[15]}}, sh[15:0]};
      LHU:     ext = {16'h0000, sh[15:0]};
      // Word offset is always 0 here, so sh is the raw word.
      LW:      ext = sh;
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: load/store stage. Takes the execute-stage effective address and
// store data, runs one request/grant/response transaction on the data-memory
// port at a time, and returns an extended load value.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   - misaligned halfword/word accesses complete at once with
//               `misaligned` set and no bus request
//   undefined - misaligned low address bits are forced to alignment and the
//               access proceeds; `misaligned` stays 0
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             begin operation (sampled only while idle)
//   mem_op            operation code
//   addr, wdata       effective address, store data
//   busy              high while not idle
//   done              one-cycle completion pulse
//   rdata             extended load result, held until the next done
//   misaligned        pulses with done on an alignment fault
//   dmem_req/we/addr/be/wdata   data-memory request channel (word aligned)
//   dmem_gnt          request accepted
//   dmem_rvalid/rdata load response
module mem_access
  import type_pkg::*;
  import mem_op_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  mem_op_t    mem_op,
  input  addr_t      addr,
  input  data_t      wdata,
  output logic       busy,
  output logic       done,
  output data_t      rdata,
  output logic       misaligned,
  output logic       dmem_req,
  output logic       dmem_we,
  output addr_t      dmem_addr,
  output logic [3:0] dmem_be,
  output data_t      dmem_wdata,
  input  logic       dmem_gnt,
  input  logic       dmem_rvalid,
  input  data_t      dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t     state;
  mem_op_t    op_q;
  logic [1:0] addr_lo_q;
  logic [1:0] start_lo;
  data_t      ext_data;

  // Drop the low address bits the access size cannot use.
  function automatic logic [1:0] align_lo(input mem_op_t op, input logic [1:0] lo);
    case (op)
      LH, LHU, SH: align_lo = {lo[1], 1'b0};
      LW, SW:      align_lo = 2'b00;
      default:     align_lo = lo;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input mem_op_t op, input logic [1:0] lo);
    case (op)
      LB, LBU, SB: lane_be = 4'b0001 << lo;
      LH, LHU, SH: lane_be = lo[1] ? 4'b1100 : 4'b0011;
      default:     lane_be = 4'b1111;
    endcase
  endfunction

  // Replicate the store data across every lane it may land in, so memory
  // only needs the byte enables to pick the right bytes.
  function automatic data_t store_data(input mem_op_t op, input data_t wd);
    case (op)
      SB:      store_data = {4{wd[7:0]}};
      SH:      store_data = {2{wd[15:0]}};
      SW:      store_data = wd;
      default: store_data = '0;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] lo);
    case (op)
      LH, LHU, SH: is_misaligned = lo[0];
      LW, SW:      is_misaligned = |lo;
      default:     is_misaligned = 1'b0;
    endcase
  endfunction
`endif

  assign start_lo = align_lo(mem_op, addr[1:0]);

  load_extend u_load_extend (
    .op      (op_q),
    .addr_lo (addr_lo_q),
    .raw     (dmem_rdata),
    .ext     (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= MEM_NONE;
      addr_lo_q  <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= '0;
      misaligned <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= 4'b0000;
      dmem_wdata <= '0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (!(is_load(mem_op) || is_store(mem_op))) begin
              state <= DONE;
              done  <= 1'b1;
`ifdef MISALIGN_TRAP_EN
            end else if (is_misaligned(mem_op, addr[1:0])) begin
              state      <= DONE;
              done       <= 1'b1;
              misaligned <= 1'b1;
`endif
            end else begin
              state      <= REQ;
              op_q       <= mem_op;
              addr_lo_q  <= start_lo;
              dmem_req   <= 1'b1;
              dmem_we    <= is_store(mem_op);
              dmem_addr  <= {addr[31:2], 2'b00};
              dmem_be    <= lane_be(mem_op, start_lo);
              dmem_wdata <= store_data(mem_op, wdata);
            end
          end
        end
        // Request fields are held untouched until the grant.
        REQ: begin
          if (dmem_gnt) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= '0;
            if (is_store(op_q)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (dmem_rvalid) begin
            rdata <= ext_data;
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  import type_pkg::*;
  import mem_op_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  mem_op_t    mem_op;
  addr_t      addr;
  data_t      wdata;
  logic       busy, done, misaligned;
  data_t      rdata;
  logic       dmem_req, dmem_we;
  addr_t      dmem_addr;
  logic [3:0] dmem_be;
  data_t      dmem_wdata;
  logic       dmem_gnt, dmem_rvalid;
  data_t      dmem_rdata;

  int checks = 0;
  int errors = 0;

  // Reference value of the rdata register.
  data_t hold_rdata;

  // Observations from the last transaction.
  int         o_done_cyc, o_req_cycles;
  logic       o_stable, o_busy_ok, o_be_ok, o_busy_after, o_done_after, o_we, o_mis;
  logic [3:0] o_be;
  data_t      o_wd, o_rdata;
  addr_t      o_addr;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_op(mem_op), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misaligned(misaligned), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  // ---------------- reference model ----------------
  function automatic int m_size(input mem_op_t op);
    if (op inside {LB, LBU, SB}) return 1;
    if (op inside {LH, LHU, SH}) return 2;
    return 4;
  endfunction

  function automatic bit m_store(input mem_op_t op);
    return op inside {SB, SH, SW};
  endfunction

  function automatic bit m_mis(input mem_op_t op, input addr_t a);
`ifdef MISALIGN_TRAP_EN
    if (op == MEM_NONE) return 1'b0;
    return (a % m_size(op)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_off(input mem_op_t op, input addr_t a);
    return ((a % 4) / m_size(op)) * m_size(op);
  endfunction

  function automatic logic [3:0] m_be(input mem_op_t op, input addr_t a);
    int lanes;
    lanes = (1 << m_size(op)) - 1;
    return 4'(lanes << m_off(op, a));
  endfunction

  function automatic data_t m_wdata(input mem_op_t op, input data_t wd);
    if (m_size(op) == 1) return (wd & 32'hFF) * 32'h01010101;
    if (m_size(op) == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic data_t m_load(input mem_op_t op, input addr_t a, input data_t raw);
    longint v, span;
    if (m_size(op) == 4) return raw;
    span = longint'(1) << (8 * m_size(op));
    v = longint'(raw >> (8 * m_off(op, a))) % span;
    if ((op inside {LB, LH}) && v >= span / 2) v = v - span;
    return data_t'(v);
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input mem_op_t op, input addr_t a, input data_t wd,
                        input int gd, input int rd, input data_t raw);
    int cyc, gnt_cyc;
    logic [3:0] r4;
    logic [68:0] first;
    o_done_cyc = -1; o_req_cycles = 0; o_stable = 1; o_busy_ok = 1; o_be_ok = 1;
    o_be = 0; o_wd = 0; o_addr = 0; o_we = 0; o_rdata = 0; o_mis = 0;
    first = '0; gnt_cyc = 0;
    @(posedge clk); #1;
    start = 1'b1; mem_op = op; addr = a; wdata = wd;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    @(posedge clk); #1;
    cyc = 1;
    while (cyc <= 40 && o_done_cyc < 0) begin
      // start while busy must be ignored, so throw junk at it
      start = done ? 1'b0 : 1'($urandom_range(0, 1));
      r4 = 4'($urandom_range(0, 8)); mem_op = mem_op_t'(r4);
      addr = $urandom; wdata = $urandom;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
      if (dmem_req) begin
        o_req_cycles++;
        if (o_req_cycles == 1) begin
          first = {dmem_we, dmem_addr, dmem_be, dmem_wdata};
          o_we = dmem_we; o_addr = dmem_addr; o_be = dmem_be; o_wd = dmem_wdata;
        end else if (first !== {dmem_we, dmem_addr, dmem_be, dmem_wdata}) begin
          o_stable = 1'b0;
        end
        if (o_req_cycles == gd + 1) begin
          dmem_gnt = 1'b1; gnt_cyc = cyc;
        end else begin
          dmem_rvalid = 1'($urandom_range(0, 1));
        end
      end else if (gnt_cyc > 0 && !m_store(op) && cyc == gnt_cyc + 1 + rd) begin
        dmem_rvalid = 1'b1; dmem_rdata = raw;
      end
      @(negedge clk);
      if (!busy) o_busy_ok = 1'b0;
      if (!dmem_req && dmem_be !== 4'b0000) o_be_ok = 1'b0;
      if (done) begin
        o_done_cyc = cyc; o_rdata = rdata; o_mis = misaligned;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    @(negedge clk);
    o_busy_after = busy; o_done_after = done;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; start = 0; mem_op = MEM_NONE; addr = 0; wdata = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0; hold_rdata = '0;
    #2;
    checks++;
    if ({busy, done, rdata, misaligned, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%0b busy=%0b done=%0b be=%h, expected all zero",
               dmem_req, busy, done, dmem_be);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_sw;
    run_op(SW, 32'h100, 32'hDEADBEEF, 0, 0, 0);
    checks++;
    if ({o_addr, o_be, o_we, o_wd} !== {32'h100, 4'b1111, 1'b1, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL sw_request: got addr=%h be=%b we=%0b wd=%h, expected 100 1111 1 deadbeef",
               o_addr, o_be, o_we, o_wd);
    end
    checks++;
    if (o_done_cyc !== 2 || o_busy_after !== 1'b0) begin
      errors++;
      $display("FAIL sw_timing: got done@%0d busy_after=%0b, expected done@2 busy_after=0",
               o_done_cyc, o_busy_after);
    end
  endtask

  task automatic test_sb_stall;
    run_op(SB, 32'h103, 32'h000000A5, 3, 0, 0);
    checks++;
    if ({o_wd, o_be} !== {32'hA5A5A5A5, 4'b1000}) begin
      errors++;
      $display("FAIL sb_steer: got wd=%h be=%b, expected a5a5a5a5 1000", o_wd, o_be);
    end
    checks++;
    if (o_req_cycles !== 4 || o_stable !== 1'b1) begin
      errors++;
      $display("FAIL sb_hold: got req_cycles=%0d stable=%0b, expected 4 1", o_req_cycles, o_stable);
    end
    checks++;
    if (o_done_cyc !== 5) begin
      errors++;
      $display("FAIL sb_done_cycle: got %0d, expected 5", o_done_cyc);
    end
  endtask

  task automatic test_lb_lbu;
    run_op(LB, 32'h202, 32'h0, 0, 0, 32'h12F03456);
    hold_rdata = 32'hFFFFFFF0;
    checks++;
    if (o_rdata !== 32'hFFFFFFF0 || o_done_cyc !== 3) begin
      errors++;
      $display("FAIL lb_signed: got rdata=%h done@%0d, expected fffffff0 done@3", o_rdata, o_done_cyc);
    end
    run_op(LBU, 32'h202, 32'h0, 0, 1, 32'h12F03456);
    hold_rdata = 32'h000000F0;
    checks++;
    if (o_rdata !== 32'h000000F0 || o_done_cyc !== 4) begin
      errors++;
      $display("FAIL lbu_zero: got rdata=%h done@%0d, expected 000000f0 done@4", o_rdata, o_done_cyc);
    end
  endtask

  task automatic test_lh;
    run_op(LH, 32'h302, 32'h0, 0, 2, 32'h80017FFF);
    hold_rdata = 32'hFFFF8001;
    checks++;
    if (o_rdata !== 32'hFFFF8001 || o_done_cyc !== 5) begin
      errors++;
      $display("FAIL lh_upper: got rdata=%h done@%0d, expected ffff8001 done@5", o_rdata, o_done_cyc);
    end
    // rdata must hold across a store
    run_op(SH, 32'h306, 32'h0000BEEF, 1, 0, 0);
    checks++;
    if (o_rdata !== 32'hFFFF8001 || {o_wd, o_be} !== {32'hBEEFBEEF, 4'b1100}) begin
      errors++;
      $display("FAIL sh_hold_rdata: got rdata=%h wd=%h be=%b, expected ffff8001 beefbeef 1100",
               o_rdata, o_wd, o_be);
    end
  endtask

  task automatic test_mem_none;
    run_op(MEM_NONE, 32'h700, 32'h1, 0, 0, 0);
    checks++;
    if (o_done_cyc !== 1 || o_req_cycles !== 0 || o_rdata !== hold_rdata) begin
      errors++;
      $display("FAIL mem_none: got done@%0d req_cycles=%0d rdata=%h, expected done@1 0 %h",
               o_done_cyc, o_req_cycles, o_rdata, hold_rdata);
    end
  endtask

  task automatic test_lw_misaligned;
    run_op(LW, 32'h401, 32'h0, 0, 0, 32'h89ABCDEF);
`ifdef MISALIGN_TRAP_EN
    checks++;
    if (o_mis !== 1'b1 || o_done_cyc !== 1 || o_req_cycles !== 0 || o_rdata !== hold_rdata) begin
      errors++;
      $display("FAIL lw_trap: got mis=%0b done@%0d req_cycles=%0d rdata=%h, expected 1 done@1 0 %h",
               o_mis, o_done_cyc, o_req_cycles, o_rdata, hold_rdata);
    end
`else
    hold_rdata = 32'h89ABCDEF;
    checks++;
    if ({o_addr, o_be, o_mis} !== {32'h400, 4'b1111, 1'b0} || o_rdata !== 32'h89ABCDEF) begin
      errors++;
      $display("FAIL lw_force_align: got addr=%h be=%b mis=%0b rdata=%h, expected 400 1111 0 89abcdef",
               o_addr, o_be, o_mis, o_rdata);
    end
`endif
  endtask

  task automatic test_reset_mid;
    logic spurious;
    @(posedge clk); #1;
    start = 1'b1; mem_op = LW; addr = 32'h500; wdata = 0;
    @(posedge clk); #1;
    start = 1'b0; dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, rdata, misaligned, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%0b req=%0b rdata=%h, expected all zero",
               busy, dmem_req, rdata);
    end
    hold_rdata = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    spurious = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || rdata !== 32'h0 || busy !== 1'b0) spurious = 1'b1;
    end
    dmem_rvalid = 1'b0;
    checks++;
    if (spurious !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: got done=%0b rdata=%h busy=%0b, expected 0 0 0", done, rdata, busy);
    end
    run_op(LW, 32'h600, 32'h0, 1, 1, 32'h0BADCAFE);
    hold_rdata = 32'h0BADCAFE;
    checks++;
    if (o_rdata !== 32'h0BADCAFE || o_done_cyc !== 5) begin
      errors++;
      $display("FAIL reset_next_lw: got rdata=%h done@%0d, expected 0badcafe done@5", o_rdata, o_done_cyc);
    end
  endtask

  task automatic test_random;
    mem_op_t op;
    logic [3:0] r4;
    addr_t a;
    data_t wd, raw;
    int gd, rd, exp_done;
    bit bus, st;
    for (int n = 0; n < 40; n++) begin
      r4 = 4'($urandom_range(0, 8)); op = mem_op_t'(r4);
      a = $urandom; wd = $urandom; raw = $urandom;
      gd = $urandom_range(0, 3); rd = $urandom_range(0, 3);
      run_op(op, a, wd, gd, rd, raw);
      bus = (op != MEM_NONE) && !m_mis(op, a);
      st  = m_store(op);
      exp_done = !bus ? 1 : (st ? 2 + gd : 3 + gd + rd);
      if (bus && !st) hold_rdata = m_load(op, a, raw);
      checks++;
      if (o_done_cyc !== exp_done || o_rdata !== hold_rdata || o_mis !== m_mis(op, a)) begin
        errors++;
        $display("FAIL rand_%0d_result op=%0d a=%h: got done@%0d rdata=%h mis=%0b, expected done@%0d rdata=%h mis=%0b",
                 n, op, a, o_done_cyc, o_rdata, o_mis, exp_done, hold_rdata, m_mis(op, a));
      end
      checks++;
      if (o_req_cycles !== (bus ? gd + 1 : 0) || o_stable !== 1'b1 || o_be_ok !== 1'b1) begin
        errors++;
        $display("FAIL rand_%0d_bus: got req_cycles=%0d stable=%0b be_ok=%0b, expected %0d 1 1",
                 n, o_req_cycles, o_stable, o_be_ok, bus ? gd + 1 : 0);
      end
      checks++;
      if (o_busy_ok !== 1'b1 || o_busy_after !== 1'b0 || o_done_after !== 1'b0) begin
        errors++;
        $display("FAIL rand_%0d_handshake: got busy_ok=%0b busy_after=%0b done_after=%0b, expected 1 0 0",
                 n, o_busy_ok, o_busy_after, o_done_after);
      end
      if (bus) begin
        checks++;
        if (o_addr !== {a[31:2], 2'b00} || o_we !== st ||
            ((st || op == LW) && o_be !== m_be(op, a)) ||
            (st && o_wd !== m_wdata(op, wd))) begin
          errors++;
          $display("FAIL rand_%0d_req op=%0d a=%h: got addr=%h we=%0b be=%b wd=%h, expected addr=%h we=%0b be=%b wd=%h",
                   n, op, a, o_addr, o_we, o_be, o_wd, {a[31:2], 2'b00}, st, m_be(op, a), m_wdata(op, wd));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb_stall();
    test_lb_lbu();
    test_lh();
    test_mem_none();
    test_lw_misaligned();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
